// File: rtl/datapath_pkg.sv
// Shared datapath types for the register-file write-back path.
package datapath_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdata;
    logic     live;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter: pipeline write-back (port A) always wins, long-latency
// results (port B) are queued and drained into idle write-port cycles.
module regfile_wb_arbiter
  import datapath_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       a_wen,
  input  logic [4:0]                 a_wsel,
  input  logic [31:0]                a_wdata,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_wsel,
  input  logic [31:0]                b_wdata,
  output logic                       stall_req,
  output logic                       rf_wen,
  output logic [4:0]                 rf_wsel,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t       fifo_q [DEPTH];
  wb_entry_t       fifo_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;

  wb_entry_t       head;
  logic            a_win;
  logic            head_valid;
  logic            head_live;
  logic            pop;
  logic            push;

  assign b_ready    = (count_q < CW'(DEPTH));
  assign fifo_count = count_q;
  assign stall_req  = stall_q;

  always_comb begin
    a_win      = a_wen && (a_wsel != '0);
    head       = fifo_q[rd_ptr_q];
    head_valid = (count_q != '0);
    head_live  = head_valid && head.live;
    // A killed head drains regardless of port A; a live head only when A is idle.
    pop        = head_valid && !(head.live && a_win);
    push       = b_valid && b_ready && (b_wsel != '0);

    rf_wen   = a_win;
    rf_wsel  = a_wsel;
    rf_wdata = a_wdata;
    if (!a_win && head_live) begin
      rf_wen   = 1'b1;
      rf_wsel  = head.wsel;
      rf_wdata = head.wdata;
    end

    // Kill older entries first so a same-cycle push (younger than A) survives.
    for (int i = 0; i < DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
      if (a_win && (fifo_q[i].wsel == a_wsel)) begin
        fifo_d[i].live = 1'b0;
      end
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{wsel: b_wsel, wdata: b_wdata, live: 1'b1};
    end

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (pop || !head_valid) begin
      starve_d = '0;
    end else if (head_live && a_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end

    stall_d = (starve_d == SW'(STARVE_MAX));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

endmodule
